// File: rtl/uart_pixel_packer.sv
`default_nettype none
// ============================================================================
// Module      : uart_pixel_packer
// Description : Packs UART bytes into multi-byte pixels and writes them into a
//               frame BRAM. Handles inter-byte timeout resync, byte order,
//               single-shot/continuous frames and frame counting.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_pixel_packer #(
  parameter int BYTES_PER_PIXEL = 3,
  parameter int PIXEL_COUNT     = 480*360,
  parameter int ADDR_W          = $clog2(PIXEL_COUNT),
  parameter bit MSB_FIRST       = 1'b1,
  parameter int TIMEOUT_CYCLES  = 1_000_000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [7:0]                   rx_data,
  input  logic                         rx_ready,
  input  logic                         continuous,
  input  logic                         restart,
  output logic                         wr_en,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic [8*BYTES_PER_PIXEL-1:0] wr_data,
  output logic                         frame_done,
  output logic                         timeout_err,
  output logic [7:0]                   frame_count,
  output logic                         busy
);

  localparam int DATA_W = 8*BYTES_PER_PIXEL;
  localparam int IDX_W  = (BYTES_PER_PIXEL > 1) ? $clog2(BYTES_PER_PIXEL) : 1;
  localparam int TMO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [IDX_W-1:0]  c_last_idx  = IDX_W'(BYTES_PER_PIXEL-1);
  localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(PIXEL_COUNT-1);
  localparam logic [TMO_W-1:0]  c_tmo_last  = TMO_W'(TIMEOUT_CYCLES-1);
  localparam bit                c_tmo_en    = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    S_RECV  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t              r_state;
  logic [IDX_W-1:0]    r_byte_idx;
  logic [DATA_W-1:0]   r_shift;
  logic [ADDR_W-1:0]   r_pix_addr;
  logic [TMO_W-1:0]    r_tmo_cnt;

  state_t              w_state;
  logic [IDX_W-1:0]    w_byte_idx;
  logic [DATA_W-1:0]   w_shift;
  logic [DATA_W-1:0]   w_pixel;
  logic [ADDR_W-1:0]   w_pix_addr;
  logic [TMO_W-1:0]    w_tmo_cnt;
  logic                w_take;
  logic                w_wr_en;
  logic [ADDR_W-1:0]   w_wr_addr;
  logic [DATA_W-1:0]   w_wr_data;
  logic                w_frame_done;
  logic                w_timeout_err;
  logic [7:0]          w_frame_count;
  logic                w_busy;

  // Next-state, datapath and registered-output values for the coming edge.
  always_comb begin
    w_state       = r_state;
    w_byte_idx    = r_byte_idx;
    w_shift       = r_shift;
    w_pix_addr    = r_pix_addr;
    w_tmo_cnt     = r_tmo_cnt;
    w_take        = 1'b0;
    w_wr_en       = 1'b0;
    w_wr_addr     = wr_addr;
    w_wr_data     = wr_data;
    w_frame_done  = 1'b0;
    w_timeout_err = 1'b0;
    w_frame_count = frame_count;

    // Current pixel with the incoming byte merged into its slot, so the
    // completing byte is already part of the written word.
    w_pixel = r_shift;
    for (int k = 0; k < BYTES_PER_PIXEL; k++) begin
      if (r_byte_idx == IDX_W'(k)) begin
        w_pixel[(MSB_FIRST ? (DATA_W-8-8*k) : (8*k)) +: 8] = rx_data;
      end
    end

    if (restart) begin
      w_state    = S_RECV;
      w_byte_idx = '0;
      w_pix_addr = '0;
      w_tmo_cnt  = '0;
    end else begin
      case (r_state)
        S_RECV: begin
          if (rx_ready) begin
            w_take = 1'b1;
          end else if (r_byte_idx == '0) begin
            w_tmo_cnt = '0;
          end else if (c_tmo_en) begin
            if (r_tmo_cnt == c_tmo_last) begin
              w_byte_idx    = '0;
              w_tmo_cnt     = '0;
              w_timeout_err = 1'b1;
            end else begin
              w_tmo_cnt = r_tmo_cnt + TMO_W'(1);
            end
          end
        end
        S_WRITE: begin
          // frame_done is high exactly during the write of the last pixel.
          if (frame_done) begin
            w_pix_addr = '0;
            w_state    = continuous ? S_RECV : S_DONE;
          end else begin
            w_pix_addr = r_pix_addr + ADDR_W'(1);
            w_state    = S_RECV;
          end
          // A byte arriving during the write starts the next pixel.
          w_take = rx_ready && (w_state == S_RECV);
        end
        S_DONE: begin
          w_state = S_DONE;
        end
        default: begin
          w_state = S_RECV;
        end
      endcase

      if (w_take) begin
        w_shift   = w_pixel;
        w_tmo_cnt = '0;
        if (r_byte_idx == c_last_idx) begin
          w_byte_idx   = '0;
          w_state      = S_WRITE;
          w_wr_en      = 1'b1;
          w_wr_addr    = w_pix_addr;
          w_wr_data    = w_pixel;
          w_frame_done = (w_pix_addr == c_last_addr);
          if (w_frame_done) begin
            w_frame_count = frame_count + 8'd1;
          end
        end else begin
          w_byte_idx = r_byte_idx + IDX_W'(1);
        end
      end
    end

    w_busy = (w_byte_idx != '0) || (w_state == S_WRITE);
  end

  // State, datapath and output registers; reset clears everything at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_RECV;
      r_byte_idx  <= '0;
      r_shift     <= '0;
      r_pix_addr  <= '0;
      r_tmo_cnt   <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      frame_done  <= 1'b0;
      timeout_err <= 1'b0;
      frame_count <= '0;
      busy        <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_byte_idx  <= w_byte_idx;
      r_shift     <= w_shift;
      r_pix_addr  <= w_pix_addr;
      r_tmo_cnt   <= w_tmo_cnt;
      wr_en       <= w_wr_en;
      wr_addr     <= w_wr_addr;
      wr_data     <= w_wr_data;
      frame_done  <= w_frame_done;
      timeout_err <= w_timeout_err;
      frame_count <= w_frame_count;
      busy        <= w_busy;
    end
  end

endmodule
`default_nettype wire
